// File: rtl/mem_stage_multicycle.sv
// Purpose : multi-cycle memory stage between the M pipeline register and writeback,
//           owning a word-organised data memory (optional MEMSTAGE_SUBWORD_EN adds lb/lh/lbu/lhu/sb/sh).
// Latency : loads/stores MEM_LATENCY cycles, other instructions 1 cycle.
// Backpressure: StallM holds the M register and earlier stages while a load/store is in flight.
// Ports   : clk, rst (sync, active-high); M-side inputs ValidM, ALUResultM, WriteDataM, PCPlus4M,
//           RdM, RegWriteM, MemWriteM, ResultSrcM, MemSizeM; StallM out; W-register outputs
//           ValidW, ALUResultW, ReadDataW, PCPlus4W, RdW, RegWriteW, ResultSrcW.
module mem_stage_multicycle #(
    parameter int WORD_SIZE   = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int MEM_LATENCY = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ValidM,
    input  logic [WORD_SIZE-1:0] ALUResultM,
    input  logic [WORD_SIZE-1:0] WriteDataM,
    input  logic [WORD_SIZE-1:0] PCPlus4M,
    input  logic [4:0]           RdM,
    input  logic                 RegWriteM,
    input  logic                 MemWriteM,
    input  logic [1:0]           ResultSrcM,
    input  logic [2:0]           MemSizeM,
    output logic                 StallM,
    output logic                 ValidW,
    output logic [WORD_SIZE-1:0] ALUResultW,
    output logic [WORD_SIZE-1:0] ReadDataW,
    output logic [WORD_SIZE-1:0] PCPlus4W,
    output logic [4:0]           RdW,
    output logic                 RegWriteW,
    output logic [1:0]           ResultSrcW
);

    localparam int AW = $clog2(MEM_DEPTH);
    // Keep the counter at least one bit wide so MEM_LATENCY=1 still elaborates.
    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic                 is_load;
    logic                 mem_op;
    logic                 complete;
    logic                 mem_we;
    logic [AW-1:0]        idx;
    logic [WORD_SIZE-1:0] rd_word;
    logic [WORD_SIZE-1:0] wr_word;
    logic [WORD_SIZE-1:0] load_val;

    logic [WORD_SIZE-1:0] mem [MEM_DEPTH];

    assign is_load  = (ResultSrcM == 2'b01);
    assign mem_op   = ValidM & (MemWriteM | is_load);
    assign StallM   = mem_op & (cnt_q != CNT_LAST) & ~rst;
    // Non-memory ops never stall, so one term covers both completion kinds.
    assign complete = ValidM & ~StallM & ~rst;
    assign mem_we   = complete & mem_op & MemWriteM;
    assign idx      = ALUResultM[AW+1:2];
    assign rd_word  = mem[idx];

    // Occupancy FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (mem_op && (MEM_LATENCY > 1)) begin
                    state_d = S_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef MEMSTAGE_SUBWORD_EN
    // Lane selection assumes 32-bit words: byte lane ALUResultM[1:0], half lane ALUResultM[1].
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    assign rd_byte = rd_word[{ALUResultM[1:0], 3'b000} +: 8];
    assign rd_half = rd_word[{ALUResultM[1], 4'b0000} +: 16];

    always_comb begin
        load_val = rd_word;
        case (MemSizeM)
            3'b000:  load_val = {{(WORD_SIZE-8){rd_byte[7]}}, rd_byte};
            3'b001:  load_val = {{(WORD_SIZE-16){rd_half[15]}}, rd_half};
            3'b100:  load_val = {{(WORD_SIZE-8){1'b0}}, rd_byte};
            3'b101:  load_val = {{(WORD_SIZE-16){1'b0}}, rd_half};
            default: load_val = rd_word;
        endcase
    end

    // Read-modify-write merge: only the addressed lanes change.
    always_comb begin
        wr_word = WriteDataM;
        case (MemSizeM)
            3'b000: begin
                wr_word = rd_word;
                wr_word[{ALUResultM[1:0], 3'b000} +: 8] = WriteDataM[7:0];
            end
            3'b001: begin
                wr_word = rd_word;
                wr_word[{ALUResultM[1], 4'b0000} +: 16] = WriteDataM[15:0];
            end
            default: wr_word = WriteDataM;
        endcase
    end
`else
    logic unused_size;
    assign unused_size = ^MemSizeM;
    assign load_val    = rd_word;
    assign wr_word     = WriteDataM;
`endif

    // Memory array: not reset; written once on a store's completion edge.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= wr_word;
        end
    end

    // M/W register
    always_ff @(posedge clk) begin
        if (rst) begin
            ValidW     <= 1'b0;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            PCPlus4W   <= '0;
            RdW        <= '0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= '0;
        end else if (complete) begin
            ValidW     <= 1'b1;
            ALUResultW <= ALUResultM;
            PCPlus4W   <= PCPlus4M;
            RdW        <= RdM;
            RegWriteW  <= RegWriteM;
            ResultSrcW <= ResultSrcM;
            if (is_load) begin
                ReadDataW <= load_val;
            end
        end else begin
            // Bubble: kill the slot, other fields hold.
            ValidW    <= 1'b0;
            RegWriteW <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage_multicycle.sv
module tb_mem_stage_multicycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        ValidM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  MemSizeM;
    logic        StallM, ValidW, RegWriteW;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
    logic [4:0]  RdW;
    logic [1:0]  ResultSrcW;

    int n_cmp = 0;
    int n_err = 0;

    mem_stage_multicycle #(.WORD_SIZE(32), .MEM_DEPTH(256), .MEM_LATENCY(5)) dut (
        .clk(clk), .rst(rst), .ValidM(ValidM), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .MemSizeM(MemSizeM), .StallM(StallM), .ValidW(ValidW),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
        .RdW(RdW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ValidM = 0; ALUResultM = 0; WriteDataM = 0; PCPlus4M = 0; RdM = 0;
        RegWriteM = 0; MemWriteM = 0; ResultSrcM = 0; MemSizeM = 3'b010;
    endtask

    // Presents one load/store and walks its 5-cycle occupancy: 4 stall cycles
    // with bubbles on W, then the completion edge.
    task automatic do_mem(input logic st, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] rd, input logic [2:0] sz, input string tag);
        ValidM = 1; MemWriteM = st; ResultSrcM = st ? 2'b00 : 2'b01; RegWriteM = ~st;
        ALUResultM = addr; WriteDataM = wd; RdM = rd; MemSizeM = sz; PCPlus4M = 32'h100;
        for (int i = 0; i < 5; i++) begin
            #1;
            check({tag, " stall"}, {31'b0, StallM}, {31'b0, (i < 4)});
            tick();
            if (i < 4) check({tag, " bubble"}, {31'b0, ValidW}, 32'd0);
        end
        check({tag, " validw"}, {31'b0, ValidW}, 32'd1);
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        tick(); tick();
        check("rst stall", {31'b0, StallM}, 32'd0);
        rst = 0;
        #1;
        check("rst validw", {31'b0, ValidW}, 32'd0);
        check("rst alu", ALUResultW, 32'd0);
        check("rst rdata", ReadDataW, 32'd0);
        check("rst pc4", PCPlus4W, 32'd0);
        check("rst rd", {27'b0, RdW}, 32'd0);
        check("rst regw", {31'b0, RegWriteW}, 32'd0);
        check("rst rsrc", {30'b0, ResultSrcW}, 32'd0);

        // One-cycle reset pulse with no traffic changes nothing.
        rst = 1; tick(); rst = 0; tick();
        check("rst2 validw", {31'b0, ValidW}, 32'd0);
        check("rst2 stall", {31'b0, StallM}, 32'd0);

        // ADD-type op: single cycle, no stall.
        ValidM = 1; RegWriteM = 1; RdM = 5'd3; ALUResultM = 32'h10; PCPlus4M = 32'h24;
        #1;
        check("add stall", {31'b0, StallM}, 32'd0);
        tick();
        check("add validw", {31'b0, ValidW}, 32'd1);
        check("add rd", {27'b0, RdW}, 32'd3);
        check("add alu", ALUResultW, 32'h10);
        check("add regw", {31'b0, RegWriteW}, 32'd1);
        check("add pc4", PCPlus4W, 32'h24);
        idle_inputs();
        tick();
        check("bubble validw", {31'b0, ValidW}, 32'd0);
        check("bubble regw", {31'b0, RegWriteW}, 32'd0);
        check("bubble hold alu", ALUResultW, 32'h10);

        // Store then back-to-back load to the same word.
        do_mem(1'b1, 32'h40, 32'hDEADBEEF, 5'd0, 3'b010, "st40");
        check("st40 regw", {31'b0, RegWriteW}, 32'd0);
        do_mem(1'b0, 32'h40, 32'h0, 5'd7, 3'b010, "ld40");
        check("ld40 data", ReadDataW, 32'hDEADBEEF);
        check("ld40 rd", {27'b0, RdW}, 32'd7);
        check("ld40 rsrc", {30'b0, ResultSrcW}, 32'd1);

        // Reset aborts a store in its third cycle.
        do_mem(1'b1, 32'h80, 32'hCAFEF00D, 5'd0, 3'b010, "st80a");
        ValidM = 1; MemWriteM = 1; ResultSrcM = 0; RegWriteM = 0;
        ALUResultM = 32'h80; WriteDataM = 32'h12345678;
        tick(); tick();
        rst = 1;
        #1;
        check("abort stall", {31'b0, StallM}, 32'd0);
        tick();
        rst = 0;
        idle_inputs();
        check("abort validw", {31'b0, ValidW}, 32'd0);
        check("abort alu", ALUResultW, 32'd0);
        tick();
        check("abort post validw", {31'b0, ValidW}, 32'd0);
        do_mem(1'b0, 32'h80, 32'h0, 5'd9, 3'b010, "ld80");
        check("ld80 data", ReadDataW, 32'hCAFEF00D);

        // Address wrap: 0x400 aliases word 0.
        do_mem(1'b1, 32'h0, 32'h5A5A0001, 5'd0, 3'b010, "st0");
        do_mem(1'b0, 32'h400, 32'h0, 5'd2, 3'b010, "ld400");
        check("ld400 data", ReadDataW, 32'h5A5A0001);
        do_mem(1'b1, 32'h7FC, 32'h0BADF00D, 5'd0, 3'b010, "st7fc");
        do_mem(1'b0, 32'h3FC, 32'h0, 5'd2, 3'b010, "ld3fc");
        check("ld3fc data", ReadDataW, 32'h0BADF00D);

`ifdef MEMSTAGE_SUBWORD_EN
        do_mem(1'b1, 32'h20, 32'h11223344, 5'd0, 3'b010, "sw20");
        do_mem(1'b1, 32'h21, 32'h000000AA, 5'd0, 3'b000, "sb21");
        do_mem(1'b0, 32'h21, 32'h0, 5'd1, 3'b000, "lb21");
        check("lb21 data", ReadDataW, 32'hFFFFFFAA);
        do_mem(1'b0, 32'h21, 32'h0, 5'd1, 3'b100, "lbu21");
        check("lbu21 data", ReadDataW, 32'h000000AA);
        do_mem(1'b0, 32'h20, 32'h0, 5'd1, 3'b010, "lw20");
        check("lw20 data", ReadDataW, 32'h1122AA44);
        do_mem(1'b0, 32'h22, 32'h0, 5'd1, 3'b001, "lh22");
        check("lh22 data", ReadDataW, 32'h00001122);
`endif

        idle_inputs();
        tick();
        check("final validw", {31'b0, ValidW}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage_multicycle.md
# mem_stage_multicycle

Parametrised multi-cycle memory stage between the execute/memory pipeline register and writeback. It owns a word-organised data memory. Loads and stores occupy the stage for a configurable number of cycles while the upstream pipeline is stalled; non-memory instructions pass through to the M/W register in one cycle. Sub-word (byte/halfword) access is optional and compiled in by macro.

## Interface
Parameters:
- `WORD_SIZE`, 32: datapath width in bits.
- `MEM_DEPTH`, 256: memory depth in words; power of two, at least 2.
- `MEM_LATENCY`, 5: cycles a load/store occupies the stage; at least 1.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ValidM` in 1: M-stage slot holds a live instruction.
- `ALUResultM` in WORD_SIZE: byte address for loads/stores, otherwise the ALU result.
- `WriteDataM` in WORD_SIZE: store data.
- `PCPlus4M` in WORD_SIZE: link value.
- `RdM` in 5: destination register.
- `RegWriteM` in 1: register write enable.
- `MemWriteM` in 1: store.
- `ResultSrcM` in 2: 2'b01 marks a load; other codes pass through unchanged.
- `MemSizeM` in 3: funct3 size/sign code; used only with `MEMSTAGE_SUBWORD_EN`.
- `StallM` out 1: hold the M register and all earlier stages.
- `ValidW`, `ALUResultW`, `ReadDataW`, `PCPlus4W`, `RdW`, `RegWriteW`, `ResultSrcW` out (1, WORD_SIZE, WORD_SIZE, WORD_SIZE, 5, 1, 2): M/W register outputs.

## Operation
- mem_op = ValidM & (MemWriteM | ResultSrcM==2'b01).
- Word index = ALUResultM[log2(MEM_DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*MEM_DEPTH bytes.
- Occupancy counter `cnt` (0..MEM_LATENCY-1), two states:
  - IDLE (cnt=0): if mem_op and MEM_LATENCY>1, go to WAIT with cnt<=1. Otherwise stay in IDLE.
  - WAIT: cnt increments each cycle. When cnt==MEM_LATENCY-1, return to IDLE with cnt<=0.
- StallM = mem_op & (cnt != MEM_LATENCY-1) & ~rst. This is combinational. The upstream logic holds the M inputs stable while StallM is high.
- Completion cycle: the cycle in which mem_op is true and StallM=0, or any cycle with a non-memory ValidM. At its edge:
  - A store writes memory exactly once.
  - A load registers the read data into ReadDataW.
  - All M fields are copied to their W registers and ValidW<=1.
- Stall cycles: ValidW<=0 and RegWriteW<=0, which inserts a bubble. The other W fields hold.
- ValidM=0: same as a stall cycle, a bubble.
- Memory contents are not cleared by reset.

## Timing
- Reset: every W output is 0, StallM=0, cnt=0, state IDLE.
- Reset asserted mid-access: cnt clears, no memory write occurs, and no W update is produced for the aborted instruction.
- Load/store latency: MEM_LATENCY cycles from first presentation to the W-register update. StallM is high for the first MEM_LATENCY-1 of those cycles.
- Non-memory instruction latency: 1 cycle. StallM stays 0.
- Back-to-back memory ops: the next op is presented in the cycle after completion and starts at cnt=0. There is no dead cycle.
- MEM_LATENCY=1: StallM is never asserted and the block behaves as a single-cycle memory stage.
- Load directly after a store to the same word: the load returns the stored value, because the store wrote on its completion edge.

## Configuration
- `MEMSTAGE_SUBWORD_EN` defined:
  - MemSizeM selects the access size: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu for loads; 000 sb, 001 sh, 010 sw for stores.
  - Byte lane is ALUResultM[1:0]; halfword lane is ALUResultM[1].
  - Stores modify only the addressed lanes.
  - Loads are extracted from the addressed lanes, then sign- or zero-extended.
  - Misaligned halfword or word accesses ignore the low address bits that are not valid for their size.
- Not defined: every access is a full word, MemSizeM is ignored, and ALUResultM[1:0] is ignored.

## Test plan
- Reset, MEM_LATENCY=5 → all W outputs 0, StallM=0; asserting rst for one cycle with no traffic changes nothing.
- ADD-type op (RegWriteM=1, RdM=3, ALUResultM=0x10) → next cycle ValidW=1, RdW=3, ALUResultW=0x10; StallM never high.
- Store 0xDEADBEEF to 0x40, then load from 0x40 → StallM high for 4 cycles per op; load result appears 5 cycles after presentation with ReadDataW=0xDEADBEEF; ValidW=0 during the stall cycles.
- Reset pulsed during cycle 3 of a store of 0x12345678 to 0x80, then a load from 0x80 → the load returns the previous contents; no write occurred.
- Address 0x400 with MEM_DEPTH=256 → aliases word 0 and returns the value stored at 0x0.
- With `MEMSTAGE_SUBWORD_EN`: sw 0x11223344 to 0x20, then sb 0xAA to 0x21, then lb 0x21 → 0xFFFFFFAA; lbu 0x21 → 0x000000AA; lw 0x20 → 0x1122AA44.
